// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, S-box tables and SubBytes engine enums.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} subbytes_state_e;
    typedef enum logic {SUB_FWD, SUB_INV} sub_mode_e;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox.sv
// Combinational forward S-box lookup (SubBytes, one byte).
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/sbox_inv.sv
// Combinational inverse S-box lookup (InvSubBytes, one byte).
module sbox_inv
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    assign out_byte = INV_SBOX[in_byte];
endmodule

// File: rtl/subbytes_engine.sv
// Iterative SubBytes/InvSubBytes engine: LANES bytes substituted per cycle,
// BEATS = STATE_BYTES/LANES cycles per word, valid/ready on both sides.
module subbytes_engine
    import aes_pkg::*;
#(
    parameter int STATE_BYTES = 16,
    parameter int LANES       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*STATE_BYTES-1:0] in_data,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*STATE_BYTES-1:0] out_data,
    output logic                     busy
);
    localparam int BEATS = STATE_BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    subbytes_state_e state, state_nx;
    sub_mode_e       mode;
    logic [CW-1:0]   cnt;

    // Work register viewed as BEATS groups of LANES bytes; group b holds bytes b*LANES..
    logic [BEATS-1:0][LANES-1:0][7:0] work;
    logic [LANES-1:0][7:0]            lane_in, lane_fwd, lane_inv, lane_out;
    logic [BEATS-1:0]                 beat_sel;
    logic                             accept, last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign out_data  = work;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_sel[b] = (cnt == CW'(b));
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox     u_fwd (.in_byte(lane_in[l]), .out_byte(lane_fwd[l]));
        sbox_inv u_inv (.in_byte(lane_in[l]), .out_byte(lane_inv[l]));
        assign lane_out[l] = (mode == SUB_INV) ? lane_inv[l] : lane_fwd[l];
    end

    always_comb begin
        lane_in = '0;
        for (int b = 0; b < BEATS; b++)
            if (beat_sel[b]) lane_in = work[b];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_RUN;
            ST_RUN:  if (last_beat) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = in_valid ? ST_RUN : ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // in_ready in DONE follows out_ready so a new word can load on the draining edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin in_ready = 1'b1; busy = 1'b0; end
            ST_RUN:  ;
            ST_DONE: begin out_valid = 1'b1; in_ready = out_ready; end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            mode <= SUB_FWD;
            cnt  <= '0;
        end else if (accept) begin
            work <= in_data;
            mode <= sub_mode_e'(in_inv);
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            for (int b = 0; b < BEATS; b++)
                if (beat_sel[b]) work[b] <= lane_out;
            cnt <= last_beat ? '0 : cnt + 1'b1;
        end
    end

endmodule
